// File: rtl/encode83_serial.sv
// encode83_serial: accepts an 8-bit request vector over valid/ready and
// serializes the 3-bit index of every set bit, one per output beat, in
// ascending (MSB_FIRST=0) or descending (MSB_FIRST=1) order. It also reports
// a last-beat flag, the popcount of the accepted vector, and a one-cycle pulse
// when an all-zero vector is accepted.
module encode83_serial #(
  parameter int MSB_FIRST = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [3:0] count,
  output logic       none
);

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  state_t     state;
  state_t     state_d;
  logic [7:0] pend;
  logic [7:0] pend_d;
  logic [3:0] count_d;
  logic       none_d;
  logic [2:0] idx;
  logic       single;
  logic [3:0] in_pop;
  logic       accept;

  // Index of the next bit to emit; the final matching iteration wins, so the
  // scan direction selects lowest-first or highest-first priority.
  always_comb begin
    idx = '0;
    if (MSB_FIRST != 0) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (pend[i]) idx = i[2:0];
      end
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (pend[7 - i]) idx = 3'(7 - i);
      end
    end
  end

  // Exactly one pending bit means the current beat is the final one.
  always_comb begin
    single = (pend != '0) && ((pend & (pend - 8'd1)) == '0);
  end

  // Popcount of the incoming vector, captured on a nonzero accept.
  always_comb begin
    in_pop = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      in_pop = in_pop + {3'b000, in[i]};
    end
  end

  // Handshake and output decode, all combinational from the state and pend.
  always_comb begin
    in_ready  = en && (state == IDLE);
    accept    = in_valid && in_ready;
    out_valid = (state == EMIT);
    out       = out_valid ? idx : '0;
    out_last  = out_valid && single;
  end

  // Next-state logic: accept in IDLE, retire one bit per taken beat in EMIT.
  always_comb begin
    state_d = state;
    pend_d  = pend;
    count_d = count;
    none_d  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in != '0) begin
            pend_d  = in;
            count_d = in_pop;
            state_d = EMIT;
          end else begin
            none_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (single) begin
            pend_d  = '0;
            state_d = IDLE;
          end else begin
            pend_d = pend & ~(8'd1 << idx);
          end
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = '0;
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pend  <= '0;
      count <= '0;
      none  <= 1'b0;
    end else begin
      state <= state_d;
      pend  <= pend_d;
      count <= count_d;
      none  <= none_d;
    end
  end

endmodule

// File: tb/tb_encode83_serial.sv
// Testbench for encode83_serial: both emission orders run side by side on the
// same stimulus and are compared every cycle against a queue-based model.
module tb_encode83_serial;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] in;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready0, out_valid0, out_last0, none0;
  logic [2:0] out0;
  logic [3:0] count0;
  logic       in_ready1, out_valid1, out_last1, none1;
  logic [2:0] out1;
  logic [3:0] count1;

  int n_assert;
  int n_fail;

  // Model: pending codes in emission order for each instance.
  int         q0[$];
  int         q1[$];
  logic [3:0] mcount;
  logic       mnone;

  encode83_serial #(.MSB_FIRST(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in), .in_valid(in_valid),
    .in_ready(in_ready0), .out(out0), .out_valid(out_valid0),
    .out_ready(out_ready), .out_last(out_last0), .count(count0), .none(none0)
  );

  encode83_serial #(.MSB_FIRST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in), .in_valid(in_valid),
    .in_ready(in_ready1), .out(out1), .out_valid(out_valid1),
    .out_ready(out_ready), .out_last(out_last1), .count(count1), .none(none1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic       ev;
    logic [2:0] eo0, eo1;
    logic       el;
    ev  = (q0.size() != 0);
    eo0 = ev ? 3'(q0[0]) : 3'd0;
    eo1 = ev ? 3'(q1[0]) : 3'd0;
    el  = ev && (q0.size() == 1);
    chk("in_ready0",  {7'd0, in_ready0},  {7'd0, en && !ev});
    chk("out_valid0", {7'd0, out_valid0}, {7'd0, ev});
    chk("out0",       {5'd0, out0},       {5'd0, eo0});
    chk("out_last0",  {7'd0, out_last0},  {7'd0, el});
    chk("count0",     {4'd0, count0},     {4'd0, mcount});
    chk("none0",      {7'd0, none0},      {7'd0, mnone});
    chk("in_ready1",  {7'd0, in_ready1},  {7'd0, en && !ev});
    chk("out_valid1", {7'd0, out_valid1}, {7'd0, ev});
    chk("out1",       {5'd0, out1},       {5'd0, eo1});
    chk("out_last1",  {7'd0, out_last1},  {7'd0, el});
    chk("count1",     {4'd0, count1},     {4'd0, mcount});
    chk("none1",      {7'd0, none1},      {7'd0, mnone});
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_update();
    logic acc;
    acc   = in_valid && en && (q0.size() == 0);
    if (q0.size() != 0 && out_ready) begin
      void'(q0.pop_front());
      void'(q1.pop_front());
    end
    mnone = acc && (in == 8'd0);
    if (acc && in != 8'd0) begin
      mcount = 4'($countones(in));
      for (int i = 0; i < 8; i++) begin
        if (in[i]) begin
          q0.push_back(i);
          q1.push_front(i);
        end
      end
    end
  endtask

  // Called at a falling edge with inputs already set; returns at the next one.
  task automatic tick();
    #1;
    check_all();
    model_update();
    @(negedge clk);
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    mcount    = '0;
    mnone     = 1'b0;
    rst_n     = 1'b0;
    en        = 1'b1;
    in        = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", {7'd0, out_valid0 | out_valid1}, 8'd0);
    chk("rst_count",     {4'd0, count0 | count1},         8'd0);
    rst_n = 1'b1;
    tick();

    // Order and last: 1001_0010 with no backpressure.
    in = 8'b1001_0010; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in = '0;
    repeat (5) tick();

    // Backpressure on 0000_1100.
    in = 8'b0000_1100; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    repeat (3) tick();

    // Single zero vector, then back-to-back zeros.
    in = 8'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    repeat (2) tick();

    // Full vector with en dropped during the burst.
    in = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; en = 1'b0;
    repeat (8) tick();
    tick();
    en = 1'b1;
    repeat (2) tick();

    // Randomized traffic.
    for (int c = 0; c < 300; c++) begin
      in        = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      en        = ($urandom_range(0, 5) != 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; en = 1'b1;
    repeat (10) tick();

    // Reset mid-emission of F0 after two beats.
    in = 8'hF0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid0", {7'd0, out_valid0}, 8'd0);
    chk("arst_out0",       {5'd0, out0},       8'd0);
    chk("arst_count0",     {4'd0, count0},     8'd0);
    chk("arst_out_valid1", {7'd0, out_valid1}, 8'd0);
    chk("arst_out1",       {5'd0, out1},       8'd0);
    chk("arst_count1",     {4'd0, count1},     8'd0);
    q0.delete();
    q1.delete();
    mcount = '0;
    mnone  = 1'b0;
    #2;
    rst_n = 1'b1;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
